// File: rtl/mprj_arb_pkg.sv
// mprj_arb_pkg: shared FSM/owner types and response constants for the bus arbiter
package mprj_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
    typedef enum logic {OWN_WB, OWN_LA} owner_t;
    localparam logic [31:0] RDATA_TIMEOUT = 32'hFFFF_FFFF;
    localparam logic [31:0] RDATA_MISS = 32'h0;
endpackage

// File: rtl/mprj_arb_watchdog.sv
// mprj_arb_watchdog: counts cycles spent waiting on the target and flags expiry
module mprj_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign expired = en && (cnt == CW'(TIMEOUT));
    // wait counter: zero outside the wait window, saturates at expiry
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mprj_bus_arbiter.sv
// mprj_bus_arbiter: decodes, round-robin arbitrates and watchdogs WB/LA access to one register target
module mprj_bus_arbiter
    import mprj_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] BASE_MASK = 32'hFFF0_0000,
    parameter int          ADDR_W    = 16,
    parameter int          TIMEOUT   = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic              la_req,
    input  logic              la_we,
    input  logic [ADDR_W-1:0] la_adr,
    input  logic [31:0]       la_wdata,
    output logic [31:0]       la_rdata,
    output logic              la_done,
    output logic              tgt_req,
    output logic              tgt_we,
    output logic [3:0]        tgt_sel,
    output logic [ADDR_W-1:0] tgt_adr,
    output logic [31:0]       tgt_wdata,
    input  logic [31:0]       tgt_rdata,
    input  logic              tgt_ack,
    input  logic              irq_clr,
    output logic              timeout_irq
);
    arb_state_t  state;
    owner_t      owner, last_grant;
    logic        la_armed, expired;
    logic        wb_pend, wb_hit, la_pend, wb_miss, grant_wb, grant_la;
    logic [31:0] resp_data;

    mprj_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (state != ISSUE),
        .en      (state == ISSUE),
        .expired (expired)
    );

    // request decode and round-robin grant; a WB miss is answered locally without a grant
    always_comb begin
        wb_pend   = wbs_cyc_i & wbs_stb_i;
        wb_hit    = (wbs_adr_i & BASE_MASK) == BASE_ADDR;
        la_pend   = la_req & la_armed;
        wb_miss   = (state == IDLE) & wb_pend & ~wb_hit;
        grant_wb  = (state == IDLE) & wb_pend & wb_hit & (~la_pend | (last_grant == OWN_LA));
        grant_la  = (state == IDLE) & la_pend & (~wb_pend | (wb_hit & (last_grant == OWN_WB)));
        resp_data = ~tgt_ack ? RDATA_TIMEOUT : tgt_we ? 32'h0 : tgt_rdata;
    end

    // transaction FSM with all outputs registered; response pulses live only in RESP
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            owner       <= OWN_WB;
            last_grant  <= OWN_LA;
            la_armed    <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            la_done     <= 1'b0;
            la_rdata    <= '0;
            tgt_req     <= 1'b0;
            tgt_we      <= 1'b0;
            tgt_sel     <= '0;
            tgt_adr     <= '0;
            tgt_wdata   <= '0;
            timeout_irq <= 1'b0;
        end else begin
            wbs_ack_o   <= 1'b0;
            la_done     <= 1'b0;
            la_armed    <= grant_la ? 1'b0 : (la_armed | ~la_req);
            timeout_irq <= ((state == ISSUE) & expired & ~tgt_ack) | (timeout_irq & ~irq_clr);
            case (state)
                IDLE: begin
                    if (wb_miss) begin
                        owner     <= OWN_WB;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= RDATA_MISS;
                        state     <= RESP;
                    end else if (grant_wb || grant_la) begin
                        owner      <= grant_wb ? OWN_WB : OWN_LA;
                        last_grant <= grant_wb ? OWN_WB : OWN_LA;
                        tgt_req    <= 1'b1;
                        tgt_we     <= grant_wb ? wbs_we_i : la_we;
                        tgt_sel    <= grant_wb ? wbs_sel_i : 4'hF;
                        tgt_adr    <= grant_wb ? wbs_adr_i[ADDR_W-1:0] : la_adr;
                        tgt_wdata  <= grant_wb ? wbs_dat_i : la_wdata;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tgt_ack || expired) begin
                        tgt_req   <= 1'b0;
                        wbs_ack_o <= owner == OWN_WB;
                        la_done   <= owner == OWN_LA;
                        if (owner == OWN_WB)
                            wbs_dat_o <= resp_data;
                        else
                            la_rdata <= resp_data;
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mprj_bus_arbiter.sv
// tb_mprj_bus_arbiter: directed and randomized checks of the WB/LA arbiter against a transaction-level model
module tb_mprj_bus_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic        la_req, la_we, la_done;
    logic [15:0] la_adr;
    logic [31:0] la_wdata, la_rdata;
    logic        tgt_req, tgt_we, tgt_ack;
    logic [3:0]  tgt_sel;
    logic [15:0] tgt_adr;
    logic [31:0] tgt_wdata, tgt_rdata;
    logic        irq_clr, timeout_irq;
    logic [120:0] outs;

    int vectors = 0;
    int miscompares = 0;
    bit la_last;
    bit exp_irq;
    int dones, nreq;
    bit bad;

    mprj_bus_arbiter #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .la_req(la_req), .la_we(la_we), .la_adr(la_adr), .la_wdata(la_wdata),
        .la_rdata(la_rdata), .la_done(la_done),
        .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_sel(tgt_sel), .tgt_adr(tgt_adr),
        .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack),
        .irq_clr(irq_clr), .timeout_irq(timeout_irq)
    );

    assign outs = {wbs_ack_o, la_done, tgt_req, tgt_we, timeout_irq, tgt_sel, tgt_adr, tgt_wdata, wbs_dat_o, la_rdata};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // plays the target: acks (with rd) in the (dly+1)-th cycle of tgt_req, stops at the first response pulse
    task automatic serve(input int dly, input logic [31:0] rd, output int rc, output int reqs,
                         output logic [1:0] pl, output logic [52:0] cap);
        rc = -1; reqs = 0; pl = 2'b00; cap = 'x;
        for (int c = 1; c <= 40 && rc < 0; c++) begin
            @(negedge clk);
            tgt_ack = 1'b0;
            if (tgt_req) begin
                reqs++;
                if (reqs == 1) cap = {tgt_we, tgt_sel, tgt_adr, tgt_wdata};
            end
            if (wbs_ack_o || la_done) begin
                rc = c;
                pl = {wbs_ack_o, la_done};
            end else if (tgt_req && reqs == dly + 1) begin
                tgt_ack = 1'b1;
                tgt_rdata = rd;
            end
        end
    endtask

    // single-requester transaction checked against the spec's latency/data rules
    task automatic xact(input string tag, input bit is_la, input logic [31:0] adr, input bit we,
                        input logic [3:0] sel, input logic [31:0] wd, input int dly, input logic [31:0] rd);
        int rc, reqs;
        logic [1:0] pl;
        logic [52:0] cap;
        bit miss, to;
        logic [31:0] exp_d;
        miss = !is_la && ((adr & 32'hFFF0_0000) != 32'h3000_0000);
        to = !miss && dly > TO;
        exp_d = miss ? 32'h0 : to ? 32'hFFFF_FFFF : we ? 32'h0 : rd;
        @(negedge clk);
        if (is_la) begin
            la_req = 1'b1; la_we = we; la_adr = adr[15:0]; la_wdata = wd;
        end else begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = wd;
        end
        serve(dly, rd, rc, reqs, pl, cap);
        chk({tag, "_port"}, pl, is_la ? 2'b01 : 2'b10);
        chk({tag, "_lat"}, rc, miss ? 1 : to ? TO + 2 : dly + 2);
        chk({tag, "_reqcyc"}, reqs, miss ? 0 : to ? TO + 1 : dly + 1);
        if (!miss) chk({tag, "_issue"}, cap, {we, is_la ? 4'hF : sel, adr[15:0], wd});
        chk({tag, "_data"}, is_la ? la_rdata : wbs_dat_o, exp_d);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; la_req = 1'b0;
        if (!miss) la_last = is_la;
        if (to) exp_irq = 1'b1;
        @(negedge clk);
        chk({tag, "_onepulse"}, {wbs_ack_o, la_done}, 2'b00);
        chk({tag, "_irq"}, timeout_irq, exp_irq);
    endtask

    // simultaneous WB and LA reads: the requester that did not win last goes first
    task automatic tie(input string tag, input logic [31:0] wadr, input logic [15:0] ladr,
                       input logic [31:0] rd1, input logic [31:0] rd2);
        int rc, reqs;
        logic [1:0] pl;
        logic [52:0] cap;
        bit wb_first;
        wb_first = la_last;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'h3; wbs_adr_i = wadr;
        la_req = 1'b1; la_we = 1'b0; la_adr = ladr;
        serve(1, rd1, rc, reqs, pl, cap);
        chk({tag, "_first"}, pl, wb_first ? 2'b10 : 2'b01);
        chk({tag, "_adr1"}, cap[47:32], wb_first ? wadr[15:0] : ladr);
        chk({tag, "_dat1"}, wb_first ? wbs_dat_o : la_rdata, rd1);
        if (wb_first) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        end else la_req = 1'b0;
        serve(1, rd2, rc, reqs, pl, cap);
        chk({tag, "_second"}, pl, wb_first ? 2'b01 : 2'b10);
        chk({tag, "_adr2"}, cap[47:32], wb_first ? ladr : wadr[15:0]);
        chk({tag, "_dat2"}, wb_first ? la_rdata : wbs_dat_o, rd2);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; la_req = 1'b0;
        la_last = wb_first;
        @(negedge clk);
        chk({tag, "_onepulse"}, {wbs_ack_o, la_done}, 2'b00);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        la_req = 0; la_we = 0; la_adr = 0; la_wdata = 0;
        tgt_ack = 0; tgt_rdata = 0; irq_clr = 0;
        la_last = 1'b1; exp_irq = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, '0);
        wb_rst_i = 1'b0;
        @(negedge clk);

        tie("tie0", 32'h3000_0040, 16'h0080, 32'hA1A1_0001, 32'hB2B2_0002);
        xact("wb_rd", 1'b0, 32'h3000_0010, 1'b0, 4'hF, 32'h0, 3, 32'h1234_5678);
        tie("tie1", 32'h3000_0044, 16'h0084, 32'hC3C3_0003, 32'hD4D4_0004);
        xact("wb_miss", 1'b0, 32'h2000_0000, 1'b0, 4'hF, 32'h0, 0, 32'hAAAA_AAAA);
        xact("la_wr", 1'b1, 32'h0000_0100, 1'b1, 4'h0, 32'hCAFE_F00D, 1, 32'h7777_7777);
        xact("wb_wr", 1'b0, 32'h300F_FFFC, 1'b1, 4'h5, 32'h0BAD_BEEF, 0, 32'h6666_6666);

        xact("timeout", 1'b0, 32'h3000_0100, 1'b0, 4'hF, 32'h0, 99, 32'h0);
        @(negedge clk);
        tgt_ack = 1'b1; tgt_rdata = 32'h0000_DEAD;
        @(negedge clk);
        tgt_ack = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bad |= tgt_req | wbs_ack_o | la_done;
        end
        chk("late_ack_ignored", bad, 1'b0);
        chk("late_ack_dat", wbs_dat_o, 32'hFFFF_FFFF);
        chk("irq_held", timeout_irq, 1'b1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        exp_irq = 1'b0;
        chk("irq_cleared", timeout_irq, 1'b0);

        @(negedge clk);
        la_req = 1'b1; la_we = 1'b0; la_adr = 16'h0042;
        dones = 0; nreq = 0;
        repeat (20) begin
            @(negedge clk);
            tgt_ack = 1'b0;
            if (la_done) dones++;
            if (tgt_req) begin
                nreq++;
                tgt_ack = 1'b1;
                tgt_rdata = 32'h0000_BEEF;
            end
        end
        tgt_ack = 1'b0;
        chk("la_hold_done", dones, 1);
        chk("la_hold_req", nreq, 1);
        chk("la_hold_data", la_rdata, 32'h0000_BEEF);
        la_req = 1'b0;
        la_last = 1'b1;
        xact("la_again", 1'b1, 32'h0000_0044, 1'b0, 4'h0, 32'h0, 0, 32'h5555_0000);

        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0020;
        @(negedge clk);
        chk("rst_pre_req", tgt_req, 1'b1);
        @(negedge clk);
        la_req = 1'b1; wb_rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", outs, '0);
        wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bad |= tgt_req | wbs_ack_o | la_done;
        end
        chk("rst_la_not_accepted", bad, 1'b0);
        la_req = 1'b0;
        la_last = 1'b1; exp_irq = 1'b0;

        for (int i = 0; i < 30; i++) begin
            int mode;
            mode = $urandom_range(0, 3);
            if (mode == 3)
                tie("rnd_tie", {12'h300, 20'($urandom)}, 16'($urandom), $urandom, $urandom);
            else if (mode == 1)
                xact("rnd_miss", 1'b0, {12'h400 + 12'($urandom_range(0, 255)), 20'($urandom)}, 1'($urandom),
                     4'($urandom), $urandom, 0, $urandom);
            else
                xact(mode == 2 ? "rnd_la" : "rnd_wb", mode == 2, {12'h300, 20'($urandom)}, 1'($urandom),
                     4'($urandom), $urandom, $urandom_range(0, 6), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                irq_clr = 1'b1;
                @(negedge clk);
                irq_clr = 1'b0;
                exp_irq = 1'b0;
                chk("rnd_irq_clr", timeout_irq, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mprj_bus_arbiter.md
# mprj_bus_arbiter

Arbitrates one register-bus target inside the user project between two requesters: the Caravel management Wishbone slave port and a logic-analyzer (LA) command port driven from `la_data_in`. It sits between the wrapper-level `wbs_*`/`la_*` signals and the core's register bus. It performs address decode, round-robin arbitration and a response watchdog, and raises a sticky user IRQ on target timeout.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000: Wishbone window base.
- `BASE_MASK`, 32'hFFF0_0000: bits compared against `BASE_ADDR`.
- `ADDR_W`, 16: target byte-address width.
- `TIMEOUT`, 255: maximum wait cycles for `tgt_ack`.

Ports (clock and reset first):
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic slave controls.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` in 32: address and write data.
- `wbs_dat_o` out 32: read data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `la_req` in 1: LA request level.
- `la_we` in 1: LA write.
- `la_adr` in ADDR_W: LA address.
- `la_wdata` in 32: LA write data.
- `la_rdata` out 32: LA read data.
- `la_done` out 1: one-cycle LA completion pulse.
- `tgt_req` out 1: target request level.
- `tgt_we` out 1: target write.
- `tgt_sel` out 4: target byte selects.
- `tgt_adr` out ADDR_W: target address.
- `tgt_wdata` out 32: target write data.
- `tgt_rdata` in 32: target read data, valid with `tgt_ack`.
- `tgt_ack` in 1: one-cycle target acknowledge.
- `irq_clr` in 1: clears the timeout IRQ.
- `timeout_irq` out 1: sticky timeout flag, routed to `user_irq[0]`.

## Operation
- Wishbone pending: `wbs_cyc_i & wbs_stb_i`. Hit: `(wbs_adr_i & BASE_MASK) == BASE_ADDR`.
- LA pending: `la_req & la_armed`.
  - `la_armed` resets to 0.
  - `la_armed` sets on any cycle where `la_req == 0`.
  - `la_armed` clears on grant. Each LA transaction therefore needs `la_req` low, then high.
- States: IDLE, ISSUE, RESP.
- IDLE transitions:
  - Wishbone miss: go to RESP with response data 0. The target is not touched.
  - Exactly one pending hit: grant it.
  - Both pending: grant the requester that is not `last_grant`. `last_grant` resets to LA, so Wishbone wins the first tie.
  - On grant: register `we`, `sel` (LA uses 4'hF), `adr[ADDR_W-1:0]` and `wdata` into the `tgt_*` outputs, update `last_grant`, go to ISSUE.
- ISSUE:
  - `tgt_req` = 1. The watchdog counter starts at 0 on entry.
  - `tgt_ack` = 1: capture `tgt_rdata` and go to RESP. A target ack wins over an expiry in the same cycle.
  - Otherwise the counter increments. At count == TIMEOUT the response data becomes 32'hFFFF_FFFF, `timeout_irq` sets, and the FSM goes to RESP.
- RESP:
  - Wishbone owner: pulse `wbs_ack_o` with `wbs_dat_o` = response data.
  - LA owner: pulse `la_done` with `la_rdata` = response data.
  - Always return to IDLE.
- `tgt_ack` outside ISSUE (including a late ack after timeout) is ignored.
- `timeout_irq`: set wins over `irq_clr` in the same cycle.
- Writes return response data 0, or all-ones on timeout.

## Timing
- All outputs are registered. Reset values:
  - `wbs_ack_o`, `la_done`, `tgt_req`, `tgt_we`, `timeout_irq` = 0.
  - `tgt_sel`, `tgt_adr`, `tgt_wdata`, `wbs_dat_o`, `la_rdata` = 0.
  - FSM = IDLE.
- Latency, request seen in IDLE at cycle 0:
  - `tgt_req` is high from cycle 1.
  - A target ack in cycle k ≥ 1 gives the response pulse in cycle k+1.
  - Minimum request-to-ack latency is 2 cycles.
  - A Wishbone miss acks at cycle 1.
- Timeout: `tgt_req` is high for TIMEOUT+1 cycles, then the response pulse follows the next cycle.
- `wbs_dat_o` and `la_rdata` hold their value until the next response to that port.
- The Wishbone master holds `cyc`/`stb` until ack. A stale `stb` in the cycle after ack is never seen, because RESP is followed by IDLE.
- Reset mid-transaction: the FSM returns to IDLE the next edge, the transaction is dropped with no ack or done pulse, and all outputs return to their reset values.

## Structure
- Package `mprj_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE/ISSUE/RESP);
  - the `owner_t` enum (OWN_WB/OWN_LA);
  - constants `RDATA_TIMEOUT` = 32'hFFFF_FFFF and `RDATA_MISS` = 32'h0.
- Sub-module `mprj_arb_watchdog` contains the counter. Inputs: clear, enable, TIMEOUT parameter. Output: `expired`.

## Test plan
- WB read at 0x3000_0010, target acks 3 cycles after `tgt_req` with 0x1234_5678 -> `tgt_adr` = 0x0010; `wbs_ack_o` pulses once with `wbs_dat_o` = 0x1234_5678.
- WB and LA requesting in the same cycle after reset -> WB granted first, LA second. A repeated tie alternates the grant.
- WB access at 0x2000_0000 -> `tgt_req` never rises; ack at cycle 1 with data 0.
- Target silent with TIMEOUT = 4 -> `tgt_req` high for 5 cycles; response data 0xFFFF_FFFF; `timeout_irq` = 1. A late `tgt_ack` is ignored. `irq_clr` clears the flag.
- `la_req` held high for 20 cycles -> exactly one `la_done`. A second transaction occurs only after `la_req` goes low.
- `wb_rst_i` asserted during ISSUE -> no ack or done pulse; all outputs 0 the next cycle; `la_req` held high through reset is not accepted.
